// File: rtl/data_path_unit.sv
// Single-issue datapath: register file, ALU and an IDLE/WB/MUL sequencer with operand forwarding.
// Define DATA_PATH_MUL_EN to build the shift-add multiplier and MUL state; otherwise MUL decodes as illegal.
module data_path_unit #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic            reg_write,
  input  logic [XLEN-1:0] imm_op,
  input  logic            alu_src,
  input  logic [3:0]      alu_ctrl,
  output logic            in_ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            eq_out,
  output logic            illegal,
  output logic [XLEN-1:0] a0
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [AW-1:0] A0_IDX = AW'(10);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_MUL  = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1
`ifdef DATA_PATH_MUL_EN
    , S_MUL = 2'd2
`endif
  } state_e;

  state_e          r_state;
  logic [XLEN-1:0] r_regs [NREG];
  logic [XLEN-1:0] r_result;
  logic            r_eq;
  logic            r_illegal;
  logic            r_done;
  logic            r_in_ready;
  logic [AW-1:0]   r_rd;
  logic            r_we;

  logic            w_issue;
  logic            w_wb_commit;
  logic            w_fwd1;
  logic            w_fwd2;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_rs2_val;
  logic [XLEN-1:0] w_op2;
  logic            w_eq;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_alu_res;
  logic            w_alu_illegal;

  assign w_issue     = in_valid && r_in_ready;
  assign w_wb_commit = (r_state == S_WB) && r_we && !r_illegal && (r_rd != '0);

  // The retiring value is written on the same edge a WB-cycle issue samples its operands.
  assign w_fwd1 = w_wb_commit && (r_rd == rs1);
  assign w_fwd2 = w_wb_commit && (r_rd == rs2);

  assign w_op1     = (rs1 == '0) ? '0 : (w_fwd1 ? r_result : r_regs[rs1]);
  assign w_rs2_val = (rs2 == '0) ? '0 : (w_fwd2 ? r_result : r_regs[rs2]);
  assign w_op2     = alu_src ? imm_op : w_rs2_val;
  assign w_eq      = (w_op1 == w_op2);
  assign w_shamt   = w_op2[SHW-1:0];

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    w_alu_res     = '0;
    w_alu_illegal = 1'b0;
    case (alu_ctrl)
      ALU_ADD:  w_alu_res = w_op1 + w_op2;
      ALU_SUB:  w_alu_res = w_op1 - w_op2;
      ALU_AND:  w_alu_res = w_op1 & w_op2;
      ALU_OR:   w_alu_res = w_op1 | w_op2;
      ALU_XOR:  w_alu_res = w_op1 ^ w_op2;
      ALU_SLL:  w_alu_res = w_op1 << w_shamt;
      ALU_SRL:  w_alu_res = w_op1 >> w_shamt;
      ALU_SRA:  w_alu_res = $unsigned($signed(w_op1) >>> w_shamt);
      ALU_SLT:  w_alu_res = XLEN'($signed(w_op1) < $signed(w_op2));
      ALU_SLTU: w_alu_res = XLEN'(w_op1 < w_op2);
`ifdef DATA_PATH_MUL_EN
      ALU_MUL:  w_alu_res = '0;
`endif
      default:  w_alu_illegal = 1'b1;
    endcase
  end

`ifdef DATA_PATH_MUL_EN
  localparam int CW = $clog2(XLEN + 1);

  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_mul_eq;
  logic            r_busy;
  logic            w_is_mul;
  logic [XLEN-1:0] w_acc_next;

  assign w_is_mul   = (alu_ctrl == ALU_MUL);
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign busy       = r_busy;
`else
  assign busy       = 1'b0;
`endif

  // NOTE: all state here uses <=, so the WB write-back and a same-edge issue both see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_result   <= '0;
      r_eq       <= 1'b0;
      r_illegal  <= 1'b0;
      r_done     <= 1'b0;
      r_in_ready <= 1'b1;
      r_rd       <= '0;
      r_we       <= 1'b0;
      // NOTE: the register file is cleared entry by entry on reset, so it must stay in flops, not a RAM.
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
`ifdef DATA_PATH_MUL_EN
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_mul_eq   <= 1'b0;
      r_busy     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_wb_commit) r_regs[r_rd] <= r_result;

      case (r_state)
        S_IDLE, S_WB: begin
          if (w_issue) begin
            r_rd <= rd;
            r_we <= reg_write;
`ifdef DATA_PATH_MUL_EN
            if (w_is_mul) begin
              r_mcand    <= w_op1;
              r_mplier   <= w_op2;
              r_acc      <= '0;
              r_cnt      <= '0;
              r_mul_eq   <= w_eq;
              r_busy     <= 1'b1;
              r_in_ready <= 1'b0;
              r_state    <= S_MUL;
            end else
`endif
            begin
              r_result  <= w_alu_res;
              r_eq      <= w_eq;
              r_illegal <= w_alu_illegal;
              r_done    <= 1'b1;
              r_state   <= S_WB;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end

`ifdef DATA_PATH_MUL_EN
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CW'(XLEN - 1)) begin
            r_result   <= w_acc_next;
            r_eq       <= r_mul_eq;
            r_illegal  <= 1'b0;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b1;
            r_state    <= S_WB;
          end
        end
`endif

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready = r_in_ready;
  assign done     = r_done;
  assign result   = r_result;
  assign eq_out   = r_eq;
  assign illegal  = r_illegal;

  generate
    if (NREG > 10) begin : g_a0
      assign a0 = r_regs[A0_IDX];
    end else begin : g_no_a0
      assign a0 = '0;
    end
  endgenerate

endmodule

// File: tb/tb_data_path_unit.sv
// Self-checking bench for data_path_unit: vector table plus a retire scoreboard keyed on the done pulse.
// Multiplier sequences run only when DATA_PATH_MUL_EN is defined; otherwise MUL is checked as illegal.
`timescale 1ns/1ps
module tb_data_path_unit;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [AW-1:0]   rs1 = '0, rs2 = '0, rd = '0;
  logic            reg_write = 1'b0;
  logic [XLEN-1:0] imm_op = '0;
  logic            alu_src = 1'b0;
  logic [3:0]      alu_ctrl = '0;
  logic            in_ready, busy, done, eq_out, illegal;
  logic [XLEN-1:0] result, a0;

  data_path_unit #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .rs1(rs1), .rs2(rs2), .rd(rd),
    .reg_write(reg_write), .imm_op(imm_op), .alu_src(alu_src), .alu_ctrl(alu_ctrl),
    .in_ready(in_ready), .busy(busy), .done(done), .result(result),
    .eq_out(eq_out), .illegal(illegal), .a0(a0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]      ctrl;
    logic [AW-1:0]   rs1, rs2, rd;
    logic            we, src;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] exp_res;
    logic            exp_eq, exp_ill;
  } vec_t;

  typedef struct {
    logic [XLEN-1:0] res;
    logic            eq, ill;
    int              cyc;
    string           name;
  } sb_t;

  sb_t  sb[$];
  vec_t vecs[20];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
  endtask

  function automatic vec_t mk(input int ctrl, input int r1, input int r2, input int d,
                              input bit we, input bit src, input logic [XLEN-1:0] imm,
                              input logic [XLEN-1:0] res, input bit eq, input bit ill);
    vec_t v;
    v.ctrl = 4'(ctrl); v.rs1 = AW'(r1); v.rs2 = AW'(r2); v.rd = AW'(d);
    v.we = we; v.src = src; v.imm = imm;
    v.exp_res = res; v.exp_eq = eq; v.exp_ill = ill;
    return v;
  endfunction

  // Drives one request, waits (bounded) for acceptance, and queues its expected retirement.
  task automatic issue(input vec_t v, input string name, input int lat, input bit push);
    int   waited;
    sb_t  e;
    waited = 0;
    alu_ctrl = v.ctrl; rs1 = v.rs1; rs2 = v.rs2; rd = v.rd;
    reg_write = v.we; alu_src = v.src; imm_op = v.imm;
    in_valid = 1'b1;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    check({name, "_accept"}, XLEN'(in_ready), 1);
    if (in_ready) begin
      if (push) begin
        e.res = v.exp_res; e.eq = v.exp_eq; e.ill = v.exp_ill;
        e.cyc = cyc + 1 + lat; e.name = name;
        sb.push_back(e);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (done) begin
      check("done_has_pending", XLEN'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        sb_t e;
        e = sb.pop_front();
        check({e.name, "_result"},  result, e.res);
        check({e.name, "_eq"},      XLEN'(eq_out), XLEN'(e.eq));
        check({e.name, "_illegal"}, XLEN'(illegal), XLEN'(e.ill));
        check({e.name, "_cycle"},   cyc, e.cyc);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

  initial begin
    int nb;
    vecs[0]  = mk(0,  0,  0,  1, 1, 1, 32'd7,         32'd7,         0, 0);
    vecs[1]  = mk(1,  1,  0,  2, 1, 1, 32'd9,         32'hFFFF_FFFE, 0, 0);
    vecs[2]  = mk(0,  2,  1,  3, 1, 0, 32'd0,         32'd5,         0, 0);
    vecs[3]  = mk(4,  3, 10,  4, 1, 0, 32'd0,         32'd0,         1, 0);
    vecs[4]  = mk(3,  1,  0,  5, 1, 1, 32'hF0,        32'hF7,        0, 0);
    vecs[5]  = mk(2,  5,  0,  6, 1, 1, 32'h3C,        32'h34,        0, 0);
    vecs[6]  = mk(5,  1,  0,  7, 1, 1, 32'h24,        32'h70,        0, 0);
    vecs[7]  = mk(0,  0,  0,  8, 1, 1, 32'h8000_0000, 32'h8000_0000, 0, 0);
    vecs[8]  = mk(7,  8,  0,  9, 1, 1, 32'h21,        32'hC000_0000, 0, 0);
    vecs[9]  = mk(6,  8,  0, 11, 1, 1, 32'h21,        32'h4000_0000, 0, 0);
    vecs[10] = mk(0,  0,  0, 12, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    vecs[11] = mk(8, 12,  0, 13, 1, 1, 32'd1,         32'd1,         0, 0);
    vecs[12] = mk(9, 12,  0, 14, 1, 1, 32'd1,         32'd0,         0, 0);
    vecs[13] = mk(0,  0,  0,  0, 1, 1, 32'h123,       32'h123,       0, 0);
    vecs[14] = mk(0,  0,  0, 15, 1, 0, 32'd0,         32'd0,         1, 0);
    vecs[15] = mk(13, 1,  0,  1, 1, 1, 32'd1,         32'd0,         0, 1);
    vecs[16] = mk(0,  1,  0, 16, 1, 1, 32'd0,         32'd7,         0, 0);
    vecs[17] = mk(0,  0,  0, 17, 0, 1, 32'h55,        32'h55,        0, 0);
    vecs[18] = mk(0, 17,  0, 18, 1, 1, 32'd0,         32'd0,         1, 0);
    vecs[19] = mk(0,  9,  0, 19, 1, 0, 32'd0,         32'hC000_0000, 0, 0);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", XLEN'(in_ready), 1);
    check("rst_busy",     XLEN'(busy), 0);
    check("rst_done",     XLEN'(done), 0);
    check("rst_result",   result, 0);
    check("rst_eq",       XLEN'(eq_out), 0);
    check("rst_illegal",  XLEN'(illegal), 0);
    check("rst_a0",       a0, 0);

    issue(mk(0, 0, 0, 10, 1, 1, 32'd5, 32'd5, 0, 0), "add_a0", 0, 1);
    @(negedge clk);
    check("a0_before_commit", a0, 0);
    @(negedge clk);
    check("a0_after_commit", a0, 5);

    for (int i = 0; i < 20; i++) issue(vecs[i], $sformatf("v%0d", i), 0, 1);

    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    check("hold_done",    XLEN'(done), 0);
    check("hold_result",  result, 32'hC000_0000);
    check("hold_eq",      XLEN'(eq_out), 0);
    check("hold_illegal", XLEN'(illegal), 0);
    check("hold_a0",      a0, 5);

`ifndef DATA_PATH_MUL_EN
    issue(mk(10, 1, 0,  1, 1, 1, 32'd5, 32'd0, 0, 1), "mul_illegal", 0, 1);
    issue(mk(0,  1, 0, 25, 1, 1, 32'd0, 32'd7, 0, 0), "x1_after_mul_illegal", 0, 1);
    check("busy_tied_low", XLEN'(busy), 0);
`else
    issue(mk(0,   0, 0, 20, 1, 1, 32'h0001_0003, 32'h0001_0003, 0, 0), "ld_x20", 0, 1);
    issue(mk(10, 20, 0, 21, 1, 1, 32'd5,         32'h0005_000F, 0, 0), "mul", XLEN, 1);
    check("mul_busy",     XLEN'(busy), 1);
    check("mul_ready_lo", XLEN'(in_ready), 0);
    nb = 0;
    while (busy && nb < 100) begin
      nb++;
      @(posedge clk); #1;
    end
    check("mul_busy_cycles", nb, XLEN);
    check("mul_ready_after", XLEN'(in_ready), 1);
    issue(mk(0, 21, 0, 23, 1, 1, 32'd0, 32'h0005_000F, 0, 0), "x21_fwd", 0, 1);
    @(negedge clk);

    issue(mk(10, 20, 0, 22, 1, 1, 32'd5, 32'd0, 0, 0), "mul_abort", XLEN, 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy",     XLEN'(busy), 0);
    check("abort_in_ready", XLEN'(in_ready), 1);
    check("abort_done",     XLEN'(done), 0);
    repeat (XLEN + 4) @(negedge clk);
    issue(mk(0, 22, 0, 24, 1, 1, 32'd0, 32'd0, 1, 0), "x22_after_abort", 0, 1);
    check("abort_a0", a0, 0);
`endif

    @(negedge clk);
    rst = 1'b1;
    alu_ctrl = 4'd0; rs1 = '0; rs2 = '0; rd = AW'(10);
    reg_write = 1'b1; alu_src = 1'b1; imm_op = 32'h77;
    in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("drop_done",     XLEN'(done), 0);
    check("drop_in_ready", XLEN'(in_ready), 1);
    check("drop_result",   result, 0);
    check("drop_a0",       a0, 0);
    @(negedge clk);
    check("drop_a0_later", a0, 0);

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/data_path_unit.md
DATA_PATH_UNIT -- requirements
Module: data_path_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal range 8 or greater.
REQ-002 SHALL have parameter NREG, default 32, register count; power of two, 2 or greater; AW = clog2(NREG).
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk (input, 1, rising-edge clock) and rst (input, 1, synchronous active-high reset).
REQ-004 SHALL have inputs: in_valid 1 (issue request); rs1 AW, rs2 AW, rd AW (register addresses); reg_write 1 (write-back enable); imm_op XLEN (immediate); alu_src 1 (0: rs2 operand, 1: imm_op); alu_ctrl 4 (operation).
REQ-005 SHALL have outputs: in_ready 1 (issue accepted when high with in_valid); busy 1 (multiply in progress); done 1 (one-cycle retire pulse); result XLEN (retired value); eq_out 1 (op1==op2 of retired op); illegal 1 (retired op was illegal); a0 XLEN (committed register 10, or 0 if NREG<=10).

Function
REQ-006 SHALL decode alu_ctrl as: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed, 0/1), 9 SLTU (0/1), 10 MUL (low XLEN bits), 11-15 illegal.
REQ-007 SHALL take shift amounts from the low clog2(XLEN) bits of op2; all arithmetic SHALL wrap modulo 2^XLEN.
REQ-008 SHALL hard-wire register 0 to zero, so reads return 0 and writes are discarded.
REQ-009 SHALL implement FSM states IDLE, WB and MUL; reset state is IDLE.
REQ-010 SHALL drive in_ready=1 in IDLE and WB and in_ready=0 in MUL; an issue is accepted on any edge with in_valid && in_ready.
REQ-011 SHALL, when a non-MUL op (legal or illegal) is accepted, compute the result combinationally and register result, rd, reg_write, eq and illegal, then go to WB.
REQ-012 SHALL, when a MUL op is accepted, latch the operands and go to MUL; MUL SHALL run a shift-add loop for exactly XLEN cycles with busy=1, then go to WB.
REQ-013 In WB, done SHALL be 1 for exactly one cycle, and result, eq_out and illegal SHALL be valid.
REQ-014 On the edge leaving WB, the unit SHALL write result to rd if reg_write=1, rd!=0 and illegal=0.
REQ-015 From WB, the next state SHALL be WB or MUL for a new accepted issue, otherwise IDLE.
REQ-016 Latency: a non-MUL op accepted at edge N SHALL raise done in cycle N+1; a MUL SHALL raise done in cycle N+XLEN+1.
REQ-017 SHALL forward the WB result to operand reads issued in WB when rs equals the WB rd, the write is enabled and rd!=0.
REQ-018 SHALL not write illegal ops, SHALL pulse illegal with done for them, and SHALL set result=0 for them.
REQ-019 result, eq_out and illegal SHALL hold their values outside WB; done SHALL be 0 outside WB.
REQ-020 a0 SHALL update on the edge following a WB write to register 10.

Reset
REQ-021 rst SHALL set every register-file entry, result, eq_out, illegal, done and busy to 0, and the state to IDLE; in_ready SHALL be 1 in the cycle after reset.
REQ-022 rst asserted during MUL or WB SHALL abort the operation with no register write and no done pulse.
REQ-023 rst SHALL take priority over a simultaneous issue, and that issue SHALL be dropped.

Configuration
REQ-024 With macro DATA_PATH_MUL_EN defined, the unit SHALL include the iterative multiplier and the MUL state.
REQ-025 Without DATA_PATH_MUL_EN, alu_ctrl=10 SHALL be treated as illegal (REQ-018), the MUL state SHALL be absent and busy SHALL be tied to 0.

Verification
REQ-026 Reset, then ADD with rs1=0, imm_op=5, alu_src=1, rd=10 -> done at N+1, result=5, a0=5 one cycle later.
REQ-027 Back-to-back: ADD x1=0+7, then SUB x2=x1-imm 9 issued in WB -> forwarded result 0xFFFFFFFE, eq_out=0.
REQ-028 With DATA_PATH_MUL_EN, MUL 0x0001_0003 x 0x0000_0005 -> busy for 32 cycles, in_ready=0, done at N+33, result 0x0005_000F.
REQ-029 Without DATA_PATH_MUL_EN, alu_ctrl=10, and any build with alu_ctrl=13 -> done with illegal=1, result=0, destination unchanged.
REQ-030 Assert rst at MUL cycle 10 -> no done, destination register unchanged, IDLE with in_ready=1 after reset.
REQ-031 SRA of 0x8000_0000 by imm 0x21 -> 0xC000_0000; SLT of -1 vs 1 -> 1; SLTU of -1 vs 1 -> 0; write with rd=0 -> x0 stays 0.
